// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Definitions shared by the sinc2 filter-chain controller:
//   - state_t       : sequencer state encoding (IDLE/RELEASE/SETTLE/RUN)
//   - DEF_*         : default parameter values for the controller
// -----------------------------------------------------------------------------
package filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_SETTLE  = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   localparam int DEF_DATA_W         = 12;
   localparam int DEF_STAGES         = 3;
   localparam int DEF_SETTLE_SAMPLES = 2;
   localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/filter_out_reg.sv
// -----------------------------------------------------------------------------
// filter_out_reg
// Single-entry valid/ready capture register for decimated filter words.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop any pending word and zero sample_cnt
//   cap_req         : strobe seen while the sequencer is in RUN
//   cap_data        : word to capture with cap_req
//   m_data/m_valid  : output word and its valid flag
//   m_ready         : consumer accept
//   clr_overrun     : one-cycle clear of the sticky overrun flag
//   overrun         : sticky flag, a word was dropped
//   sample_cnt      : number of words accepted (wraps)
// -----------------------------------------------------------------------------
module filter_out_reg
   import filter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              cap_req,
   input  logic [DATA_W-1:0] cap_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   input  logic              clr_overrun,
   output logic              overrun,
   output logic [CNT_W-1:0]  sample_cnt
);

   logic [DATA_W-1:0] m_data_r;
   logic              m_valid_r;
   logic              overrun_r;
   logic [CNT_W-1:0]  sample_cnt_r;
   logic              slot_free_s;
   logic              drop_s;

   // The slot can take a new word if empty or being drained on this edge.
   always_comb begin
      slot_free_s = (!m_valid_r) || m_ready;
      drop_s      = cap_req && m_valid_r && !m_ready;
   end

   // Capture register, handshake and accepted-word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_data_r     <= '0;
         m_valid_r    <= 1'b0;
         sample_cnt_r <= '0;
      end else if (flush) begin
         m_valid_r    <= 1'b0;
         sample_cnt_r <= '0;
      end else if (cap_req && slot_free_s) begin
         m_data_r     <= cap_data;
         m_valid_r    <= 1'b1;
         sample_cnt_r <= sample_cnt_r + CNT_W'(1);
      end else if (m_valid_r && m_ready) begin
         m_valid_r    <= 1'b0;
      end else begin
         m_valid_r    <= m_valid_r;
      end
   end

   // Sticky overrun flag; a new drop beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end else if (clr_overrun) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

   assign m_data     = m_data_r;
   assign m_valid    = m_valid_r;
   assign overrun    = overrun_r;
   assign sample_cnt = sample_cnt_r;

endmodule

// File: rtl/digital_filter_ctrl.sv
// -----------------------------------------------------------------------------
// digital_filter_ctrl
// Sequencer and output controller for the sinc2 decimation chain.
// Ports:
//   clk, rst        : filter clock, synchronous active-high reset
//   enable          : 1 = run the filter, 0 = hold it in reset
//   filt_rst_n      : staged per-stage active-low resets, bit 0 = first stage
//   filt_data       : decimated word, valid with filt_new_data
//   m_data/m_valid/m_ready : valid/ready output towards the consumer
//   overrun/clr_overrun    : sticky dropped-word flag and its clear
//   running         : 1 while the sequencer is in RUN
//   sample_cnt      : number of words accepted into m_data
// -----------------------------------------------------------------------------
module digital_filter_ctrl
   import filter_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int STAGES         = DEF_STAGES,
   parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic [STAGES-1:0] filt_rst_n,
   input  logic [DATA_W-1:0] filt_data,
   input  logic              filt_new_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              overrun,
   input  logic              clr_overrun,
   output logic              running,
   output logic [CNT_W-1:0]  sample_cnt
);

   localparam int SC_W = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES + 1);
   localparam logic [SC_W-1:0] SETTLE_LAST =
      SC_W'((SETTLE_SAMPLES > 0) ? (SETTLE_SAMPLES - 1) : 0);
   // Where the sequencer goes once the last stage is out of reset.
   localparam state_t POST_RELEASE = (SETTLE_SAMPLES == 0) ? ST_RUN : ST_SETTLE;

   state_t            state_r;
   logic [STAGES-1:0] filt_rst_n_r;
   logic [STAGES-1:0] rst_n_next_s;
   logic [SC_W-1:0]   settle_cnt_r;
   logic              running_r;
   logic              flush_s;
   logic              cap_req_s;

   // Next staged-reset pattern: one more stage released per clock.
   always_comb begin
      rst_n_next_s = (filt_rst_n_r << 1) | STAGES'(1);
      flush_s      = (state_r != ST_IDLE) && !enable;
      cap_req_s    = (state_r == ST_RUN) && filt_new_data;
   end

   // Sequencer: staged reset release, settling discard, run/disable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         filt_rst_n_r <= '0;
         settle_cnt_r <= '0;
         running_r    <= 1'b0;
      end else if (flush_s) begin
         state_r      <= ST_IDLE;
         filt_rst_n_r <= '0;
         settle_cnt_r <= '0;
         running_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               settle_cnt_r <= '0;
               if (enable) begin
                  filt_rst_n_r <= rst_n_next_s;
                  if (rst_n_next_s[STAGES-1]) begin
                     state_r   <= POST_RELEASE;
                     running_r <= (POST_RELEASE == ST_RUN);
                  end else begin
                     state_r   <= ST_RELEASE;
                     running_r <= 1'b0;
                  end
               end else begin
                  filt_rst_n_r <= '0;
                  running_r    <= 1'b0;
               end
            end
            ST_RELEASE: begin
               filt_rst_n_r <= rst_n_next_s;
               if (rst_n_next_s[STAGES-1]) begin
                  state_r   <= POST_RELEASE;
                  running_r <= (POST_RELEASE == ST_RUN);
               end else begin
                  state_r   <= ST_RELEASE;
                  running_r <= 1'b0;
               end
            end
            ST_SETTLE: begin
               // The strobe that completes settling is itself discarded.
               if (filt_new_data) begin
                  if (settle_cnt_r == SETTLE_LAST) begin
                     state_r      <= ST_RUN;
                     running_r    <= 1'b1;
                     settle_cnt_r <= '0;
                  end else begin
                     settle_cnt_r <= settle_cnt_r + SC_W'(1);
                  end
               end else begin
                  settle_cnt_r <= settle_cnt_r;
               end
            end
            ST_RUN: begin
               running_r <= 1'b1;
            end
            default: begin
               state_r      <= ST_IDLE;
               filt_rst_n_r <= '0;
               settle_cnt_r <= '0;
               running_r    <= 1'b0;
            end
         endcase
      end
   end

   filter_out_reg #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_out_reg (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush_s),
      .cap_req     (cap_req_s),
      .cap_data    (filt_data),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .clr_overrun (clr_overrun),
      .overrun     (overrun),
      .sample_cnt  (sample_cnt)
   );

   assign filt_rst_n = filt_rst_n_r;
   assign running    = running_r;

endmodule

// File: tb/tb_digital_filter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digital_filter_ctrl
// Directed self-checking bench for digital_filter_ctrl.
// -----------------------------------------------------------------------------
module tb_digital_filter_ctrl;
   import filter_pkg::*;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [2:0]  filt_rst_n;
   logic [11:0] filt_data;
   logic        filt_new_data;
   logic [11:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        overrun;
   logic        clr_overrun;
   logic        running;
   logic [15:0] sample_cnt;

   int tests_run;
   int tests_failed;

   digital_filter_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .filt_rst_n    (filt_rst_n),
      .filt_data     (filt_data),
      .filt_new_data (filt_new_data),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .overrun       (overrun),
      .clr_overrun   (clr_overrun),
      .running       (running),
      .sample_cnt    (sample_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; filt_data = 12'h000; filt_new_data = 1'b0;
      m_ready = 1'b0; clr_overrun = 1'b0;
      step(); step();
      tests_run++;
      if (filt_rst_n !== 3'b000) begin tests_failed++; $display("FAIL reset_rst_n got %b exp 000", filt_rst_n); end
      tests_run++;
      if ({m_valid, overrun, running} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b exp 000", {m_valid, overrun, running}); end
      tests_run++;
      if (m_data !== 12'h000 || sample_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_data got %h/%0d exp 000/0", m_data, sample_cnt); end
      rst = 1'b0;
      step();
      tests_run++;
      if (filt_rst_n !== 3'b000 || running !== 1'b0) begin tests_failed++; $display("FAIL idle_hold got %b/%b exp 000/0", filt_rst_n, running); end
   endtask

   // Enable and expect bits released one per edge, ending in SETTLE.
   task automatic test_release(input string tag);
      logic [2:0] exp_rst_n [3];
      exp_rst_n[0] = 3'b001; exp_rst_n[1] = 3'b011; exp_rst_n[2] = 3'b111;
      enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         tests_run++;
         if (filt_rst_n !== exp_rst_n[k]) begin tests_failed++; $display("FAIL %s_stage%0d got %b exp %b", tag, k, filt_rst_n, exp_rst_n[k]); end
      end
      tests_run++;
      if (dut.state_r !== ST_SETTLE || running !== 1'b0) begin tests_failed++; $display("FAIL %s_settle got state %0d running %b exp 2/0", tag, dut.state_r, running); end
   endtask

   // Two strobes discarded, the third captured with 1-cycle latency.
   task automatic test_settle(input string tag, input logic [11:0] last_word);
      filt_new_data = 1'b1; filt_data = 12'h111;
      step();
      tests_run++;
      if (m_valid !== 1'b0 || running !== 1'b0) begin tests_failed++; $display("FAIL %s_discard1 got v%b r%b exp v0 r0", tag, m_valid, running); end
      filt_data = 12'h222;
      step();
      tests_run++;
      if (m_valid !== 1'b0 || running !== 1'b1) begin tests_failed++; $display("FAIL %s_discard2 got v%b r%b exp v0 r1", tag, m_valid, running); end
      filt_data = last_word;
      step();
      filt_new_data = 1'b0;
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== last_word || sample_cnt !== 16'd1) begin
         tests_failed++; $display("FAIL %s_capture got v%b %h cnt%0d exp v1 %h cnt1", tag, m_valid, m_data, sample_cnt, last_word);
      end
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         filt_new_data = 1'b1; filt_data = 12'(i);
         step();
         tests_run++;
         if (m_valid !== 1'b1 || m_data !== 12'(i) || overrun !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_word%0d got v%b %h ov%b exp v1 %h ov0", i, m_valid, m_data, overrun, 12'(i));
         end
      end
      filt_new_data = 1'b0;
      tests_run++;
      if (sample_cnt !== 16'd5) begin tests_failed++; $display("FAIL b2b_cnt got %0d exp 5", sample_cnt); end
      step();
      tests_run++;
      if (m_valid !== 1'b0 || m_data !== 12'h004) begin tests_failed++; $display("FAIL b2b_drain got v%b %h exp v0 004", m_valid, m_data); end
   endtask

   task automatic test_overrun();
      m_ready = 1'b0;
      filt_new_data = 1'b1; filt_data = 12'h0AA;
      step();
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== 12'h0AA || sample_cnt !== 16'd6) begin
         tests_failed++; $display("FAIL ovr_load got v%b %h cnt%0d exp v1 0aa cnt6", m_valid, m_data, sample_cnt);
      end
      filt_data = 12'h0BB;
      step();
      tests_run++;
      if (m_data !== 12'h0AA || overrun !== 1'b1 || sample_cnt !== 16'd6) begin
         tests_failed++; $display("FAIL ovr_drop got %h ov%b cnt%0d exp 0aa ov1 cnt6", m_data, overrun, sample_cnt);
      end
      filt_data = 12'h0CC; clr_overrun = 1'b1;
      step();
      tests_run++;
      if (overrun !== 1'b1 || m_data !== 12'h0AA) begin tests_failed++; $display("FAIL ovr_set_wins got ov%b %h exp ov1 0aa", overrun, m_data); end
      filt_new_data = 1'b0;
      step();
      clr_overrun = 1'b0;
      tests_run++;
      if (overrun !== 1'b0 || m_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_clear got ov%b v%b exp ov0 v1", overrun, m_valid); end
   endtask

   task automatic test_disable();
      enable = 1'b0;
      step();
      tests_run++;
      if (filt_rst_n !== 3'b000 || m_valid !== 1'b0 || sample_cnt !== 16'd0 || running !== 1'b0) begin
         tests_failed++; $display("FAIL dis_flush got %b v%b cnt%0d r%b exp 000 v0 cnt0 r0", filt_rst_n, m_valid, sample_cnt, running);
      end
      filt_new_data = 1'b1; filt_data = 12'h777;
      step();
      filt_new_data = 1'b0;
      tests_run++;
      if (m_valid !== 1'b0 || overrun !== 1'b0) begin tests_failed++; $display("FAIL dis_idle_strobe got v%b ov%b exp v0 ov0", m_valid, overrun); end
      test_release("rel2");
      test_settle("settle2", 12'h5A5);
   endtask

   task automatic test_sync_reset();
      m_ready = 1'b0;
      filt_new_data = 1'b1; filt_data = 12'h123;
      step();
      filt_new_data = 1'b0;
      tests_run++;
      if (overrun !== 1'b1 || m_data !== 12'h5A5) begin tests_failed++; $display("FAIL srst_prep got ov%b %h exp ov1 5a5", overrun, m_data); end
      rst = 1'b1;
      step();
      rst = 1'b0; enable = 1'b0;
      tests_run++;
      if (filt_rst_n !== 3'b000 || {m_valid, overrun, running} !== 3'b000 || m_data !== 12'h000 || sample_cnt !== 16'd0) begin
         tests_failed++; $display("FAIL srst_outputs got %b %b %h %0d exp 000 000 000 0", filt_rst_n, {m_valid, overrun, running}, m_data, sample_cnt);
      end
      filt_new_data = 1'b1; filt_data = 12'h456;
      step(); step();
      filt_new_data = 1'b0;
      tests_run++;
      if (m_valid !== 1'b0 || overrun !== 1'b0 || sample_cnt !== 16'd0) begin
         tests_failed++; $display("FAIL srst_idle_strobe got v%b ov%b cnt%0d exp v0 ov0 cnt0", m_valid, overrun, sample_cnt);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_release("rel1");
      test_settle("settle1", 12'h3A5);
      test_back_to_back();
      test_overrun();
      test_disable();
      test_sync_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
